// File: rtl/axi_10g_ethernet_0_pkg.sv
// rtl/axi_10g_ethernet_0_pkg.sv - shared types and defaults for the link status filter
package axi_10g_ethernet_0_pkg;

    typedef enum logic [1:0] {
        DOWN      = 2'd0,
        UP_PEND   = 2'd1,
        UP        = 2'd2,
        DOWN_PEND = 2'd3
    } lsf_state_e;

    localparam int FILTER_CYCLES_DEFAULT = 16;
    localparam int STAB_CNT_W            = 16;

endpackage

// File: rtl/axi_10g_ethernet_0_sync_block.sv
// rtl/axi_10g_ethernet_0_sync_block.sv - multi-flop synchronizer for a single-bit level
module axi_10g_ethernet_0_sync_block #(
    parameter int C_NUM_SYNC_REGS = 5
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic data_i,
    output logic data_o
);

    logic [C_NUM_SYNC_REGS-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[C_NUM_SYNC_REGS-2:0], data_i};
        end
    end

    assign data_o = sync_q[C_NUM_SYNC_REGS-1];

endmodule

// File: rtl/axi_10g_ethernet_0_link_status_filter.sv
// rtl/axi_10g_ethernet_0_link_status_filter.sv - debounced link status with latched-low and change counter
// Optional change counter enabled by macro LINK_STATUS_CHANGE_CNT_EN.
module axi_10g_ethernet_0_link_status_filter
    import axi_10g_ethernet_0_pkg::*;
#(
    parameter int C_NUM_SYNC_REGS = 5,
    parameter int FILTER_CYCLES   = FILTER_CYCLES_DEFAULT,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             status_async,
    input  logic             clear_ll,
    output logic             status_filt,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             status_ll,
    output logic [CNT_W-1:0] change_cnt
);

    localparam logic [STAB_CNT_W-1:0] CNT_LAST = STAB_CNT_W'(FILTER_CYCLES - 1);

    logic                  status_s;
    lsf_state_e            state_q, state_d;
    logic [STAB_CNT_W-1:0] stab_q, stab_d;
    logic                  filt_q, filt_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  ll_q, ll_d;

    axi_10g_ethernet_0_sync_block #(
        .C_NUM_SYNC_REGS(C_NUM_SYNC_REGS)
    ) u_sync (
        .clk_i  (clk),
        .rst_n_i(areset_n),
        .data_i (status_async),
        .data_o (status_s)
    );

    // The PEND entry cycle counts as the first stable cycle, so the
    // transition fires when the incremented count hits FILTER_CYCLES-1.
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        case (state_q)
            DOWN: begin
                if (status_s) begin
                    state_d = UP_PEND;
                    stab_d  = '0;
                end
            end
            UP_PEND: begin
                if (!status_s) begin
                    state_d = DOWN;
                    stab_d  = '0;
                end else if (stab_q + 1'b1 == CNT_LAST) begin
                    state_d = UP;
                    stab_d  = '0;
                end else begin
                    stab_d  = stab_q + 1'b1;
                end
            end
            UP: begin
                if (!status_s) begin
                    state_d = DOWN_PEND;
                    stab_d  = '0;
                end
            end
            DOWN_PEND: begin
                if (status_s) begin
                    state_d = UP;
                    stab_d  = '0;
                end else if (stab_q + 1'b1 == CNT_LAST) begin
                    state_d = DOWN;
                    stab_d  = '0;
                end else begin
                    stab_d  = stab_q + 1'b1;
                end
            end
            default: begin
                state_d = DOWN;
                stab_d  = '0;
            end
        endcase
    end

    always_comb begin
        filt_d = (state_d == UP) || (state_d == DOWN_PEND);
        rise_d = (state_q == UP_PEND) && (state_d == UP);
        fall_d = (state_q == DOWN_PEND) && (state_d == DOWN);
        ll_d   = ll_q;
        if (fall_d) begin
            ll_d = 1'b0;
        end else if (clear_ll) begin
            ll_d = filt_q;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= DOWN;
            stab_q  <= '0;
            filt_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            ll_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            ll_q    <= ll_d;
        end
    end

    assign status_filt = filt_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign status_ll   = ll_q;

`ifdef LINK_STATUS_CHANGE_CNT_EN
    logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;

    always_comb begin
        chg_cnt_d = chg_cnt_q;
        if (clear_ll) begin
            chg_cnt_d = (rise_d || fall_d) ? CNT_W'(1) : '0;
        end else if ((rise_d || fall_d) && (chg_cnt_q != {CNT_W{1'b1}})) begin
            chg_cnt_d = chg_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            chg_cnt_q <= '0;
        end else begin
            chg_cnt_q <= chg_cnt_d;
        end
    end

    assign change_cnt = chg_cnt_q;
`else
    assign change_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_10g_ethernet_0_link_status_filter.sv
// tb/tb_axi_10g_ethernet_0_link_status_filter.sv - scoreboard bench for the link status filter
module tb_axi_10g_ethernet_0_link_status_filter;

    localparam int SYNC   = 5;
    localparam int FILT   = 16;
    localparam int CNT_W  = 2;
    localparam int CNT_MX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             areset_n;
    logic             status_async;
    logic             clear_ll;
    logic             status_filt;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             status_ll;
    logic [CNT_W-1:0] change_cnt;

    axi_10g_ethernet_0_link_status_filter #(
        .C_NUM_SYNC_REGS(SYNC),
        .FILTER_CYCLES  (FILT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .areset_n    (areset_n),
        .status_async(status_async),
        .clear_ll    (clear_ll),
        .status_filt (status_filt),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .status_ll   (status_ll),
        .change_cnt  (change_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit rise;
        bit fall;
        bit filt;
        bit ll;
        int cnt;
    } ev_t;

    ev_t exp_q[$];
    int  pend[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;
    bit  clr_at_edge = 1'b0;

    // reference model: run-length of raw samples that disagree with the filtered level
    bit  rf   = 1'b0;
    bit  of   = 1'b0;
    int  run  = 0;
    bit  mll  = 1'b0;
    int  mcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        clr_at_edge <= clear_ll;
    end

    always @(negedge clk) begin
        if (areset_n && (rise_pulse || fall_pulse || clr_at_edge)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {rise_pulse, fall_pulse, clr_at_edge}, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("rise_pulse", rise_pulse, e.rise);
                chk("fall_pulse", fall_pulse, e.fall);
                chk("status_filt", status_filt, e.filt);
                chk("status_ll", status_ll, e.ll);
                chk("change_cnt", change_cnt, e.cnt);
            end
        end
    end

    task automatic step(input bit a, input int clr_mode);
        int  e_cyc;
        bit  pulse, clr, prev_of;
        ev_t ev;
        @(negedge clk);
        #1;
        e_cyc = cyc + 1;
        pulse = 1'b0;
        if (pend.size() > 0) pulse = (pend[0] == e_cyc);
        clr = (clr_mode == 2) ||
              (clr_mode == 1 && (($urandom_range(0, 9) == 0) || (pulse && $urandom_range(0, 1) == 1)));
        status_async = a;
        clear_ll     = clr;
        prev_of      = of;
        if (pulse) begin
            void'(pend.pop_front());
            of = !of;
        end
        if (pulse && !of)  mll = 1'b0;
        else if (clr)      mll = prev_of;
        if (clr)                        mcnt = pulse ? 1 : 0;
        else if (pulse && mcnt < CNT_MX) mcnt = mcnt + 1;
        if (pulse || clr) begin
            ev.cyc  = e_cyc;
            ev.rise = pulse && of;
            ev.fall = pulse && !of;
            ev.filt = of;
            ev.ll   = mll;
`ifdef LINK_STATUS_CHANGE_CNT_EN
            ev.cnt  = mcnt;
`else
            ev.cnt  = 0;
`endif
            exp_q.push_back(ev);
        end
        if (a != rf) begin
            run++;
            if (run == FILT) begin
                pend.push_back(e_cyc + SYNC);
                rf  = !rf;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        areset_n = 1'b0;
        clear_ll = 1'b0;
        #1;
        chk("rst_status_filt", status_filt, 0);
        chk("rst_rise_pulse", rise_pulse, 0);
        chk("rst_fall_pulse", fall_pulse, 0);
        chk("rst_status_ll", status_ll, 0);
        chk("rst_change_cnt", change_cnt, 0);
        pend.delete();
        rf = 1'b0; of = 1'b0; run = 0; mll = 1'b0; mcnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        status_async = 1'b0;
        areset_n     = 1'b1;
    endtask

    initial begin
        bit lvl;
        areset_n     = 1'b0;
        status_async = 1'b0;
        clear_ll     = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_status_filt", status_filt, 0);
        chk("init_status_ll", status_ll, 0);
        chk("init_change_cnt", change_cnt, 0);
        #1;
        areset_n = 1'b1;

        // clean rise, then read the latched-low register
        repeat (30) step(1'b1, 0);
        step(1'b1, 2);
        repeat (3) step(1'b1, 0);
        // short glitch must be filtered out
        repeat (10) step(1'b0, 0);
        repeat (30) step(1'b1, 0);
        // real drop, recovery, latched-low persists until read
        repeat (40) step(1'b0, 0);
        repeat (30) step(1'b1, 0);
        step(1'b1, 2);
        repeat (2) step(1'b1, 0);
        // reset eight cycles into UP_PEND
        repeat (30) step(1'b0, 0);
        repeat (13) step(1'b1, 0);
        do_reset();
        repeat (30) step(1'b1, 0);
        step(1'b1, 2);
        // randomized levels, hold lengths and read strobes
        lvl = 1'b1;
        repeat (120) begin
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 36);
            repeat (len) step(lvl, 1);
        end
        repeat (30) step(lvl, 0);
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_status_filt", status_filt, of);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
